uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver, successor to the fixed 8N1 receiver.
//  - Configurable data width, parity, stop bits and 3-sample majority voting.
//  - Per-character parity/framing error flags, break detection, overrun flag.
//  - Received characters are buffered in a small FIFO drained by a valid/ready handshake.
//  - Sits between the board RX pin and the coprocessor command decoder.
// PARAMETERS
//  CLKS_PER_BIT  87  i_Clock cycles per bit (f_clk/baud); must be >= 8
//  DATA_BITS     8   data bits per character, 5..9, LSB first
//  PARITY_MODE   0   0=none, 1=odd, 2=even
//  STOP_BITS     1   1 or 2
//  FIFO_DEPTH    4   RX FIFO entries, power of 2, >= 2
// PORTS
//  i_Clock      in   1          system clock, all logic on rising edge
//  i_Reset      in   1          asynchronous, active-high reset
//  i_Rx_Serial  in   1          asynchronous serial line, idle high
//  o_Rx_Valid   out  1          FIFO head holds a character
//  i_Rx_Ready   in   1          consumer accepts head when o_Rx_Valid=1
//  o_Rx_Data    out  DATA_BITS  head character
//  o_Rx_Err     out  2          head flags: [0]=parity error, [1]=framing error
//  o_Overrun    out  1          sticky: char lost because FIFO full; cleared only by i_Reset
//  o_Break      out  1          one-cycle pulse on break detection
// BEHAVIOUR
//  - Reset: 2-flop synchroniser = 1, FSM = IDLE, counters = 0, FIFO emptied.
//    o_Rx_Valid/o_Overrun/o_Break = 0; o_Rx_Data/o_Rx_Err = 0.
//    Reset mid-frame aborts the frame and pushes nothing.
//  - Sampling
//    - Counter width = $clog2(CLKS_PER_BIT).
//    - MID = (CLKS_PER_BIT-1)/2.
//    - Each bit is the majority of the synchronised line at counts MID-1, MID, MID+1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP.
//    - IDLE: counter = 0. Synced line 0 -> START.
//    - START: at count MID+1, vote = 0 -> DATA; vote = 1 (glitch) -> IDLE, nothing pushed.
//    - DATA: DATA_BITS bits, one every CLKS_PER_BIT clocks at the vote point, LSB first.
//      After the last bit -> PARITY if PARITY_MODE != 0, else STOP.
//    - PARITY: sample the parity bit. perr = (XOR(data, parity bit) != expected);
//      expected = 1 for odd, 0 for even.
//    - STOP: sample STOP_BITS stop bits. ferr = 1 if any stop vote = 0.
//      At the last stop vote point -> CLEANUP, which resolves the character and
//      returns to IDLE, so a start bit arriving half a bit later is caught.
//    - Undefined state code -> IDLE.
//  - Resolve (CLEANUP cycle):
//    - Break: data == 0 && parity bit == 0 && ferr -> o_Break = 1 for one cycle, no push.
//    - Else push {perr, ferr, data}. FIFO full -> drop the character, set o_Overrun.
//  - Latency: o_Rx_Valid rises 1 clk after the CLEANUP push.
//    Rise is >= 1 clk after the last stop vote point.
//  - FIFO: first-word-fall-through; o_Rx_Data/o_Rx_Err valid whenever o_Rx_Valid = 1.
//    - Pop when o_Rx_Valid && i_Rx_Ready.
//    - Push and pop in the same cycle when full: both succeed, no overrun.
//    - Push when empty: never popped the same cycle.
//    - Read/write pointers wrap modulo FIFO_DEPTH; an extra pointer bit separates full from empty.
// STRUCTURE
//  - Shared package uart_pkg: FSM state localparams, PARITY_NONE/ODD/EVEN constants,
//    error-bit index constants.
//  - Sub-module uart_rx_fifo (WIDTH = DATA_BITS+2, DEPTH = FIFO_DEPTH):
//    synchronous FWFT FIFO with full/empty flags.
//  - Top level holds the synchroniser, voter, FSM and counters.
// TESTING  (CLKS_PER_BIT = 16 unless noted)
//  1. 8N1, send 0xA5 -> one o_Rx_Valid, data = 0xA5, err = 00.
//  2. 8E1, send 0x0F with parity bit 1 -> data = 0x0F, err = 01. Correct parity bit 0 -> err = 00.
//  3. 8N2, 0x3C with second stop bit low -> err = 10, then 0x3C correct -> err = 00.
//  4. Line low 4 clks then high -> no push; next 0x81 -> received.
//     Single-clk high glitch at the DATA mid-bit -> bit voted correctly.
//  5. FIFO_DEPTH = 4, i_Rx_Ready = 0, send 0x11..0x15
//     -> 4 entries held, o_Overrun = 1, 0x15 lost.
//     Then ready = 1 -> pops 0x11..0x14 in order, one per clk.
//  6. All-zero frame with low stop bit -> o_Break one-cycle pulse, o_Rx_Valid stays 0.
//     i_Reset pulse mid-DATA -> all outputs 0; next 0x55 -> received with err = 00.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the parametrised UART receiver:
//   - rx_state_e   : receiver FSM state encoding
//   - PARITY_*     : values accepted by the PARITY_MODE parameter
//   - ERR_*        : bit positions inside the 2-bit per-character error flags
//   - majority3()  : 2-of-3 vote used by the bit sampler
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StParity  = 3'd3,
        StStop    = 3'd4,
        StCleanup = 3'd5
    } rx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam int unsigned ERR_PARITY = 0;
    localparam int unsigned ERR_FRAME  = 1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
//   Synchronous first-word-fall-through FIFO holding received characters.
//   rdata_o shows the head entry whenever empty_o is low (zero when empty).
//   A write into a full FIFO succeeds only if a read happens in the same cycle.
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous active-high reset, empties the FIFO
//   wr_i     in   write request
//   wdata_i  in   WIDTH  write data
//   rd_i     in   read (pop) request, ignored when empty
//   rdata_o  out  WIDTH  head entry
//   full_o   out  FIFO full
//   empty_o  out  FIFO empty
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd   = rd_i && !empty_o;
    assign do_wr   = wr_i && (!full_o || do_rd);

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver: 2-flop synchroniser, 3-sample majority voter,
//   frame FSM with parity/framing checks and break detection, and an RX FIFO
//   drained through a valid/ready handshake.
// Ports
//   i_Clock      in   system clock, rising edge
//   i_Reset      in   asynchronous active-high reset
//   i_Rx_Serial  in   asynchronous serial line, idle high
//   o_Rx_Valid   out  FIFO head holds a character
//   i_Rx_Ready   in   consumer accepts head when o_Rx_Valid is high
//   o_Rx_Data    out  DATA_BITS  head character
//   o_Rx_Err     out  2  head flags: [0] parity error, [1] framing error
//   o_Overrun    out  sticky, a character was dropped on a full FIFO
//   o_Break      out  one-cycle pulse when a break is detected
// ----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_Valid,
    input  logic                 i_Rx_Ready,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic [1:0]           o_Rx_Err,
    output logic                 o_Overrun,
    output logic                 o_Break
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID    = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned FIFO_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_SAMP1 = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE  = CNT_W'(MID + 1);

    localparam logic [BIT_W-1:0] BIT_ONE   = 1;
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    // XOR of data and parity bit that a clean character produces.
    localparam logic PAR_EXPECT = (PARITY_MODE == PARITY_ODD);

    rx_state_e              state_q, state_d;
    logic [1:0]             rx_sync_q;
    logic                   rx_line;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   samp0_q, samp0_d;
    logic                   samp1_q, samp1_d;
    logic                   par_bit_q, par_bit_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   vote_pt, vote;
    logic                   push, brk, pop;
    logic                   fifo_full, fifo_empty;
    logic [FIFO_W-1:0]      fifo_rdata;

    assign rx_line = rx_sync_q[1];
    assign vote_pt = (cnt_q == CNT_VOTE);
    assign vote    = majority3(samp0_q, samp1_q, rx_line);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!rx_line) state_d = StStart;
            end
            StStart: begin
                if (vote_pt) state_d = vote ? StIdle : StData;
            end
            StData: begin
                if (vote_pt && (bit_cnt_q == LAST_DATA)) begin
                    state_d = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
                end
            end
            StParity: begin
                if (vote_pt) state_d = StStop;
            end
            StStop: begin
                if (vote_pt && (bit_cnt_q == LAST_STOP)) state_d = StCleanup;
            end
            StCleanup: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        push = 1'b0;
        brk  = 1'b0;
        if (state_q == StCleanup) begin
            // Line held low through data, parity and stop: report, do not store.
            if ((data_q == '0) && !par_bit_q && ferr_q) begin
                brk = 1'b1;
            end else begin
                push = 1'b1;
            end
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        samp0_d   = samp0_q;
        samp1_d   = samp1_q;
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        // Bit-period counter runs continuously through a frame so every vote
        // point sits exactly CLKS_PER_BIT clocks after the previous one.
        if ((state_q == StIdle) || (state_q == StCleanup) || (state_d == StIdle)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (cnt_q == CNT_SAMP0) samp0_d = rx_line;
        if (cnt_q == CNT_SAMP1) samp1_d = rx_line;

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                par_bit_d = 1'b0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
            end
            StData: begin
                if (vote_pt) begin
                    data_d    = {vote, data_q[DATA_BITS-1:1]};
                    bit_cnt_d = (bit_cnt_q == LAST_DATA) ? '0 : bit_cnt_q + BIT_ONE;
                end
            end
            StParity: begin
                if (vote_pt) begin
                    par_bit_d = vote;
                    perr_d    = ((^data_q) ^ vote) != PAR_EXPECT;
                end
            end
            StStop: begin
                if (vote_pt) begin
                    if (!vote) ferr_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            default: ;
        endcase
    end

    assign pop   = o_Rx_Valid && i_Rx_Ready;
    // A full FIFO still accepts the character if the head leaves this cycle.
    assign ovr_d = ovr_q | (push & fifo_full & ~pop);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_sync_q <= 2'b11;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            samp0_q   <= 1'b1;
            samp1_q   <= 1'b1;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], i_Rx_Serial};
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            samp0_q   <= samp0_d;
            samp1_q   <= samp1_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    uart_rx_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_i   (i_Reset),
        .wr_i    (push),
        .wdata_i ({perr_q, ferr_q, data_q}),
        .rd_i    (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign o_Rx_Valid           = !fifo_empty;
    assign o_Rx_Data            = fifo_rdata[DATA_BITS-1:0];
    assign o_Rx_Err[ERR_PARITY] = fifo_rdata[DATA_BITS+1];
    assign o_Rx_Err[ERR_FRAME]  = fifo_rdata[DATA_BITS];
    assign o_Overrun            = ovr_q;
    assign o_Break              = brk;

endmodule

// File: tb/tb_uart_rx_param.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_param
//   Three receivers at 16 clocks per bit: [0] 8N1, [1] 8E1, [2] 8N2, FIFO depth 4.
//   Frames are driven bit by bit; accepted characters and break pulses are
//   collected and compared with a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx    [3];
    logic       rdy   [3];
    logic       valid [3];
    logic [7:0] dout  [3];
    logic [1:0] err   [3];
    logic       ovr   [3];
    logic       brk   [3];

    int tests = 0;
    int fails = 0;
    int brk_cnt [3];
    int exp_brk [3];

    // Entries are {dut index, {ferr, perr}, data}.
    logic [11:0] got_q [$];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_Valid(valid[0]),
        .i_Rx_Ready(rdy[0]), .o_Rx_Data(dout[0]), .o_Rx_Err(err[0]), .o_Overrun(ovr[0]),
        .o_Break(brk[0]));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                    .FIFO_DEPTH(4)) u_e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_Valid(valid[1]),
        .i_Rx_Ready(rdy[1]), .o_Rx_Data(dout[1]), .o_Rx_Err(err[1]), .o_Overrun(ovr[1]),
        .o_Break(brk[1]));

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2),
                    .FIFO_DEPTH(4)) u_n2 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_Valid(valid[2]),
        .i_Rx_Ready(rdy[2]), .o_Rx_Data(dout[2]), .o_Rx_Err(err[2]), .o_Overrun(ovr[2]),
        .o_Break(brk[2]));

    // Collector: handshakes and break pulses, sampled away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid[d] && rdy[d]) got_q.push_back({2'(d), err[d], dout[d]});
            if (brk[d]) brk_cnt[d]++;
        end
    end

    function automatic int pmode(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic int nstop(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: what the receiver must report for a clean frame.
    function automatic void model(input int d, input logic [7:0] data, input logic par,
                                  input logic s1, input logic s2,
                                  output logic is_brk, output logic [11:0] entry);
        logic pbit, perr, ferr;
        pbit = (pmode(d) != 0) ? par : 1'b0;
        ferr = !s1 || (nstop(d) == 2 && !s2);
        if (pmode(d) == 0) perr = 1'b0;
        else perr = ((($countones(data) + int'(pbit)) % 2) == 1) != (pmode(d) == 1);
        is_brk = (data == 8'h00) && !pbit && ferr;
        entry  = {2'(d), ferr, perr, data};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the line at b for n clocks, ends at a negedge.
    task automatic drive(input int d, input logic b, input int n);
        rx[d] = b;
        repeat (n) @(negedge clk);
    endtask

    // gbit >= 0 inverts that data bit for one clock at its centre.
    task automatic send(input int d, input logic [7:0] data, input logic par, input logic s1,
                        input logic s2, input int gap, input int gbit);
        logic        is_brk;
        logic [11:0] e;
        drive(d, 1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                drive(d, data[i], 8);
                drive(d, !data[i], 1);
                drive(d, data[i], 7);
            end else begin
                drive(d, data[i], BIT);
            end
        end
        if (pmode(d) != 0) drive(d, par, BIT);
        drive(d, s1, BIT);
        if (nstop(d) == 2) drive(d, s2, BIT);
        drive(d, 1'b1, gap);
        model(d, data, par, s1, s2, is_brk, e);
        if (is_brk) exp_brk[d]++;
        else exp_q.push_back(e);
    endtask

    task automatic drain_check(input string tag);
        repeat (8) @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
        for (int d = 0; d < 3; d++) check({tag, "_break"}, brk_cnt[d], exp_brk[d]);
    endtask

    task automatic set_rdy(input int d, input logic v);
        @(posedge clk);
        #1 rdy[d] = v;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        logic       p, s1, s2;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rx[d] = 1'b1; rdy[d] = 1'b1; brk_cnt[d] = 0; exp_brk[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_valid", valid[d], 0);
            check("rst_data", dout[d], 0);
            check("rst_err", err[d], 0);
            check("rst_ovr", ovr[d], 0);
            check("rst_brk", brk[d], 0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 basic character.
        send(0, 8'hA5, 1'b0, 1'b1, 1'b1, 4, -1);
        drain_check("t1_8n1");

        // 8E1 wrong then correct parity bit.
        send(1, 8'h0F, 1'b1, 1'b1, 1'b1, 4, -1);
        send(1, 8'h0F, 1'b0, 1'b1, 1'b1, 4, -1);
        drain_check("t2_8e1");

        // 8N2 bad second stop bit, then a clean one.
        send(2, 8'h3C, 1'b0, 1'b1, 1'b0, 48, -1);
        send(2, 8'h3C, 1'b0, 1'b1, 1'b1, 4, -1);
        drain_check("t3_8n2");

        // Short start glitch rejected, then a real character with a data-bit glitch.
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 48);
        drain_check("t4_start_glitch");
        send(0, 8'h81, 1'b0, 1'b1, 1'b1, 4, 3);
        send(1, 8'h6E, 1'b1, 1'b1, 1'b1, 4, 0);
        drain_check("t4_data_glitch");

        // Randomised pairs of frames on every receiver.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 3; d++) begin
                for (int k = 0; k < 2; k++) begin
                    b  = 8'($urandom);
                    p  = ($urandom_range(3) == 0) ? !(^b) : (^b);
                    s1 = ($urandom_range(4) != 0);
                    s2 = ($urandom_range(4) != 0);
                    send(d, b, p, s1, s2, (s1 && s2) ? int'($urandom_range(20)) : 48,
                         ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1);
                end
                drain_check("rand");
            end
        end
        check("rand_ovr_e1", ovr[1], 0);
        check("rand_ovr_n2", ovr[2], 0);

        // Overrun: five characters into a four-entry FIFO with no consumer.
        set_rdy(0, 1'b0);
        for (int i = 0; i < 5; i++) send(0, 8'(8'h11 + i), 1'b0, 1'b1, 1'b1, 0, -1);
        void'(exp_q.pop_back());
        drive(0, 1'b1, 8);
        check("t5_ovr", ovr[0], 1);
        check("t5_valid", valid[0], 1);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_pop_valid", valid[0], 1);
            check("t5_pop_data", dout[0], 32'h11 + k);
        end
        @(negedge clk);
        check("t5_empty", valid[0], 0);
        drain_check("t5_order");
        check("t5_ovr_sticky", ovr[0], 1);

        // Break on 8N1 and 8E1; all-zero data with parity 1 is not a break.
        send(0, 8'h00, 1'b0, 1'b0, 1'b1, 48, -1);
        send(1, 8'h00, 1'b0, 1'b0, 1'b1, 48, -1);
        send(1, 8'h00, 1'b1, 1'b0, 1'b1, 48, -1);
        drain_check("t6_break");

        // Reset in the middle of a frame with a character held in the FIFO.
        set_rdy(0, 1'b0);
        send(0, 8'h77, 1'b0, 1'b1, 1'b1, 4, -1);
        void'(exp_q.pop_back());
        check("t6_held", valid[0], 1);
        drive(0, 1'b0, BIT);
        drive(0, 1'b1, BIT);
        drive(0, 1'b0, 8);
        rst   = 1'b1;
        rx[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_rst_valid", valid[0], 0);
        check("t6_rst_data", dout[0], 0);
        check("t6_rst_err", err[0], 0);
        check("t6_rst_ovr", ovr[0], 0);
        check("t6_rst_brk", brk[0], 0);
        rst = 1'b0;
        set_rdy(0, 1'b1);
        drive(0, 1'b1, 2 * BIT);
        drain_check("t6_after_rst_idle");
        send(0, 8'h55, 1'b0, 1'b1, 1'b1, 4, -1);
        drain_check("t6_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
